// File: rtl/fc_layer_sequential.sv
// Sequential fully-connected layer: one time-multiplexed MAC per class against an external
// 1-cycle-latency weight ROM. Define FC_ARGMAX_EN to generate the running argmax on pred_class.
module fc_layer_sequential #(
  parameter int FLATTENED_LENGTH = 432,
  parameter int NUM_CLASSES      = 10,
  parameter int DATA_WIDTH       = 8,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int ACC_WIDTH        = 32,
  parameter int ADDR_WIDTH       = $clog2(NUM_CLASSES * FLATTENED_LENGTH)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           fc_start,
  input  logic        [DATA_WIDTH-1:0]   flattened_in [FLATTENED_LENGTH],
  input  logic signed [WEIGHT_WIDTH-1:0] bias_in      [NUM_CLASSES],
  output logic        [ADDR_WIDTH-1:0]   weight_addr,
  input  logic signed [WEIGHT_WIDTH-1:0] weight_data,
  output logic                           busy,
  output logic                           fc_done,
  output logic                           scores_valid,
  output logic signed [ACC_WIDTH-1:0]    class_scores [NUM_CLASSES],
  output logic [$clog2(NUM_CLASSES)-1:0] pred_class
);

  localparam int IW = (FLATTENED_LENGTH > 1) ? $clog2(FLATTENED_LENGTH) : 1;
  localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int PW = $clog2(NUM_CLASSES);
  localparam logic [IW-1:0] LAST_IDX   = IW'(FLATTENED_LENGTH - 1);
  localparam logic [CW-1:0] LAST_CLASS = CW'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_e;

  state_e                         state_q, state_d;
  logic        [IW-1:0]           idx_q, pidx_q;
  logic        [CW-1:0]           class_q;
  logic        [ADDR_WIDTH-1:0]   addr_q;
  logic                           mac_vld_q;
  logic                           scores_valid_q;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [ACC_WIDTH-1:0]    scores_q [NUM_CLASSES];
  logic        [DATA_WIDTH-1:0]   act_q    [FLATTENED_LENGTH];
  logic signed [WEIGHT_WIDTH-1:0] bias_q   [NUM_CLASSES];

  logic signed [ACC_WIDTH-1:0]    prod, acc_sum, score;

  // Activation is unsigned, so it is zero-extended before the signed multiply.
  function automatic logic signed [ACC_WIDTH-1:0] mac_prod(
    input logic        [DATA_WIDTH-1:0]   act,
    input logic signed [WEIGHT_WIDTH-1:0] w
  );
    logic signed [ACC_WIDTH-1:0] a_ext, w_ext;
    a_ext = ACC_WIDTH'($signed({1'b0, act}));
    w_ext = ACC_WIDTH'(w);
    return a_ext * w_ext;
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sext_bias(
    input logic signed [WEIGHT_WIDTH-1:0] b
  );
    return ACC_WIDTH'(b);
  endfunction

  // mac_vld_q marks that the ROM word on weight_data belongs to the previous cycle's address.
  assign prod    = mac_vld_q ? mac_prod(act_q[pidx_q], weight_data) : '0;
  assign acc_sum = acc_q + prod;
  assign score   = acc_sum + sext_bias(bias_q[class_q]);

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    fc_done = 1'b0;
    case (state_q)
      S_IDLE:  if (fc_start) state_d = S_MAC;
      S_MAC: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) state_d = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        state_d = (class_q == LAST_CLASS) ? S_DONE : S_MAC;
      end
      S_DONE: begin
        fc_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      pidx_q         <= '0;
      class_q        <= '0;
      addr_q         <= '0;
      mac_vld_q      <= 1'b0;
      scores_valid_q <= 1'b0;
      acc_q          <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) scores_q[c] <= '0;
    end else begin
      state_q   <= state_d;
      mac_vld_q <= (state_q == S_MAC);
      pidx_q    <= idx_q;
      case (state_q)
        S_IDLE: if (fc_start) begin
          idx_q          <= '0;
          class_q        <= '0;
          addr_q         <= '0;
          acc_q          <= '0;
          scores_valid_q <= 1'b0;
        end
        S_MAC: begin
          acc_q <= acc_sum;
          if (idx_q != LAST_IDX) begin
            idx_q  <= idx_q + IW'(1);
            addr_q <= addr_q + ADDR_WIDTH'(1);
          end
        end
        S_WRITE: begin
          scores_q[class_q] <= score;
          acc_q             <= '0;
          idx_q             <= '0;
          class_q           <= class_q + CW'(1);
          // Addresses are contiguous across classes; hold the last one after the final class.
          if (class_q != LAST_CLASS) addr_q <= addr_q + ADDR_WIDTH'(1);
          else                       scores_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && state_q == S_IDLE && fc_start) begin
      act_q  <= flattened_in;
      bias_q <= bias_in;
    end
  end

`ifdef FC_ARGMAX_EN
  logic signed [ACC_WIDTH-1:0] max_q;
  logic        [PW-1:0]        pred_q;

  // Strict compare: on a tie the earlier (lower) class keeps the max.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      max_q  <= '0;
      pred_q <= '0;
    end else if (state_q == S_WRITE && (class_q == '0 || score > max_q)) begin
      max_q  <= score;
      pred_q <= PW'(class_q);
    end
  end

  assign pred_class = pred_q;
`else
  assign pred_class = '0;
`endif

  assign weight_addr  = addr_q;
  assign scores_valid = scores_valid_q;
  assign class_scores = scores_q;

endmodule

// File: tb/tb_fc_layer_sequential.sv
// Bench for fc_layer_sequential: three instances (L=4/C=2, default L=432/C=10, L=4/C=4),
// each with a synchronous ROM model; expected scores queued at start, checked at fc_done.
module tb_fc_layer_sequential;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int exp_q[$];
  int pred_q[$];
  int addr_log[$];
  bit rec = 1'b0;

  // Instance A: L=4, C=2
  logic              a_start = 1'b0;
  logic        [7:0] a_act  [4];
  logic signed [7:0] a_bias [2];
  logic signed [7:0] a_rom  [8];
  logic        [2:0] a_addr;
  logic signed [7:0] a_wd = '0;
  logic              a_busy, a_done, a_sv;
  logic signed [31:0] a_sc [2];
  logic        [0:0] a_pred;

  // Instance B: default L=432, C=10
  logic              b_start = 1'b0;
  logic        [7:0] b_act  [432];
  logic signed [7:0] b_bias [10];
  logic signed [7:0] b_rom  [4320];
  logic       [12:0] b_addr;
  logic signed [7:0] b_wd = '0;
  logic              b_busy, b_done, b_sv;
  logic signed [31:0] b_sc [10];
  logic        [3:0] b_pred;

  // Instance C: L=4, C=4
  logic              c_start = 1'b0;
  logic        [7:0] c_act  [4];
  logic signed [7:0] c_bias [4];
  logic signed [7:0] c_rom  [16];
  logic        [3:0] c_addr;
  logic signed [7:0] c_wd = '0;
  logic              c_busy, c_done, c_sv;
  logic signed [31:0] c_sc [4];
  logic        [1:0] c_pred;

  fc_layer_sequential #(.FLATTENED_LENGTH(4), .NUM_CLASSES(2)) u_a (
    .clk(clk), .reset_n(reset_n), .fc_start(a_start), .flattened_in(a_act), .bias_in(a_bias),
    .weight_addr(a_addr), .weight_data(a_wd), .busy(a_busy), .fc_done(a_done),
    .scores_valid(a_sv), .class_scores(a_sc), .pred_class(a_pred));

  fc_layer_sequential u_b (
    .clk(clk), .reset_n(reset_n), .fc_start(b_start), .flattened_in(b_act), .bias_in(b_bias),
    .weight_addr(b_addr), .weight_data(b_wd), .busy(b_busy), .fc_done(b_done),
    .scores_valid(b_sv), .class_scores(b_sc), .pred_class(b_pred));

  fc_layer_sequential #(.FLATTENED_LENGTH(4), .NUM_CLASSES(4)) u_c (
    .clk(clk), .reset_n(reset_n), .fc_start(c_start), .flattened_in(c_act), .bias_in(c_bias),
    .weight_addr(c_addr), .weight_data(c_wd), .busy(c_busy), .fc_done(c_done),
    .scores_valid(c_sv), .class_scores(c_sc), .pred_class(c_pred));

  always @(posedge clk) begin
    a_wd <= a_rom[a_addr];
    b_wd <= b_rom[b_addr];
    c_wd <= c_rom[c_addr];
  end

  always @(negedge clk) if (rec && a_busy) addr_log.push_back(int'(a_addr));

  function automatic int nclass(input int sel);
    return (sel == 0) ? 2 : (sel == 1) ? 10 : 4;
  endfunction
  function automatic int nlen(input int sel);
    return (sel == 1) ? 432 : 4;
  endfunction
  function automatic int get_act(input int sel, input int i);
    if (sel == 0) return int'(a_act[i[1:0]]);
    if (sel == 1) return int'(b_act[i]);
    return int'(c_act[i[1:0]]);
  endfunction
  function automatic int get_w(input int sel, input int a);
    if (sel == 0) return int'(a_rom[a[2:0]]);
    if (sel == 1) return int'(b_rom[a]);
    return int'(c_rom[a[3:0]]);
  endfunction
  function automatic int get_bias(input int sel, input int c);
    if (sel == 0) return int'(a_bias[c[0]]);
    if (sel == 1) return int'(b_bias[c]);
    return int'(c_bias[c[1:0]]);
  endfunction
  function automatic logic signed [31:0] get_score(input int sel, input int c);
    if (sel == 0) return a_sc[c[0]];
    if (sel == 1) return b_sc[c];
    return c_sc[c[1:0]];
  endfunction
  function automatic logic [31:0] get_pred(input int sel);
    if (sel == 0) return 32'(a_pred);
    if (sel == 1) return 32'(b_pred);
    return 32'(c_pred);
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? a_busy : (sel == 1) ? b_busy : c_busy;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 0) ? a_done : (sel == 1) ? b_done : c_done;
  endfunction

  // Computes the reference scores/argmax, queues them, and issues a one-cycle start.
  task automatic launch(input int sel);
    int s, best, bi;
    best = 0;
    bi = 0;
    @(negedge clk);
    for (int c = 0; c < nclass(sel); c++) begin
      s = get_bias(sel, c);
      for (int i = 0; i < nlen(sel); i++) s += get_act(sel, i) * get_w(sel, c * nlen(sel) + i);
      exp_q.push_back(s);
      if (c == 0 || s > best) begin best = s; bi = c; end
    end
`ifdef FC_ARGMAX_EN
    pred_q.push_back(bi);
`else
    pred_q.push_back(0);
`endif
    if (sel == 0) a_start = 1'b1; else if (sel == 1) b_start = 1'b1; else c_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
  endtask

  // Called at the negedge after the start edge; lat is the edge index at which fc_done is sampled.
  task automatic wait_done(input int sel, output int lat, output int bcnt, output bit to);
    int n;
    n = 0; bcnt = 0; to = 1'b1; lat = 0;
    while (n < 6000) begin
      if (get_busy(sel)) bcnt++;
      if (get_done(sel)) begin lat = n + 1; to = 1'b0; break; end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_sv, a_addr, a_pred, a_sc[0], a_sc[1]} !== '0)
      $display("FAIL reset_a: busy=%b done=%b sv=%b addr=%0d pred=%0d sc0=%0d sc1=%0d, required all 0",
               a_busy, a_done, a_sv, a_addr, a_pred, a_sc[0], a_sc[1]);
    else passed++;
    checks++;
    if ({b_busy, b_done, b_sv, b_addr, c_busy, c_done, c_sv, c_addr} !== '0)
      $display("FAIL reset_bc: b_busy=%b b_addr=%0d c_busy=%b c_addr=%0d, required 0",
               b_busy, b_addr, c_busy, c_addr);
    else passed++;
    reset_n = 1'b1;
  endtask

  task automatic test_basic(input string nm);
    int lat, bc, e;
    bit to;
    a_act = '{1, 2, 3, 4};
    a_rom = '{1, 1, 1, 1, -1, 0, 0, 2};
    a_bias = '{5, -3};
    launch(0);
    wait_done(0, lat, bc, to);
    checks++;
    if (to || lat !== 11) $display("FAIL %s_latency: fc_done edge %0d (timeout=%0d), required 11", nm, lat, to);
    else passed++;
    checks++;
    if (bc !== 10) $display("FAIL %s_busy_cycles: got %0d, required 10", nm, bc); else passed++;
    checks++;
    if (a_sv !== 1'b1) $display("FAIL %s_scores_valid: got %b, required 1", nm, a_sv); else passed++;
    for (int c = 0; c < 2; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (a_sc[c] !== e) $display("FAIL %s_score%0d: got %0d, required %0d", nm, c, a_sc[c], e);
      else passed++;
    end
    e = pred_q.pop_front();
    checks++;
    if (get_pred(0) !== e) $display("FAIL %s_pred: got %0d, required %0d", nm, a_pred, e); else passed++;
  endtask

  task automatic test_reset_mid;
    launch(0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    pred_q.delete();
    checks++;
    if ({a_busy, a_done, a_sv, a_addr, a_pred, a_sc[0], a_sc[1]} !== '0)
      $display("FAIL reset_mid: busy=%b done=%b sv=%b addr=%0d pred=%0d sc0=%0d sc1=%0d, required all 0",
               a_busy, a_done, a_sv, a_addr, a_pred, a_sc[0], a_sc[1]);
    else passed++;
    reset_n = 1'b1;
    test_basic("after_reset");
  endtask

  task automatic test_start_while_busy;
    int lat, bc, e;
    bit to;
    a_act = '{10, 20, 30, 40};
    a_rom = '{3, -2, 1, 5, -7, 4, 2, -1};
    a_bias = '{-20, 11};
    launch(0);
    repeat (2) @(negedge clk);
    a_start = 1'b1;
    a_act = '{200, 201, 202, 203};
    @(negedge clk);
    a_start = 1'b0;
    wait_done(0, lat, bc, to);
    checks++;
    if (to) $display("FAIL busy_start_done: timeout, required fc_done"); else passed++;
    for (int c = 0; c < 2; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (a_sc[c] !== e) $display("FAIL busy_start_score%0d: got %0d, required %0d", c, a_sc[c], e);
      else passed++;
    end
    e = pred_q.pop_front();
    checks++;
    if (get_pred(0) !== e) $display("FAIL busy_start_pred: got %0d, required %0d", a_pred, e); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat, bc, e, bad;
    int ref_q[$];
    bit to;
    addr_log.delete();
    rec = 1'b1;
    a_act = '{7, 0, 255, 9};
    a_rom = '{2, 2, -1, 0, 1, 1, 1, 1};
    a_bias = '{0, 1};
    launch(0);
    wait_done(0, lat, bc, to);
    checks++;
    if (to || a_sv !== 1'b1) $display("FAIL b2b_first_done: timeout=%0d sv=%b, required done with sv=1", to, a_sv);
    else passed++;
    for (int c = 0; c < 2; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (a_sc[c] !== e) $display("FAIL b2b_first_score%0d: got %0d, required %0d", c, a_sc[c], e);
      else passed++;
    end
    e = pred_q.pop_front();
    a_act = '{1, 1, 1, 1};
    a_rom = '{-5, 0, 0, 0, 4, 4, 4, 4};
    a_bias = '{-1, 2};
    launch(0);
    checks++;
    if (a_sv !== 1'b0) $display("FAIL b2b_valid_drop: scores_valid=%b, required 0", a_sv); else passed++;
    wait_done(0, lat, bc, to);
    rec = 1'b0;
    checks++;
    if (to || lat !== 11) $display("FAIL b2b_second_latency: edge %0d (timeout=%0d), required 11", lat, to);
    else passed++;
    for (int c = 0; c < 2; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (a_sc[c] !== e) $display("FAIL b2b_second_score%0d: got %0d, required %0d", c, a_sc[c], e);
      else passed++;
    end
    e = pred_q.pop_front();
    checks++;
    if (get_pred(0) !== e) $display("FAIL b2b_second_pred: got %0d, required %0d", a_pred, e); else passed++;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 4; i++) ref_q.push_back(c * 4 + i);
        ref_q.push_back(c * 4 + 3);
      end
    bad = (addr_log.size() != ref_q.size()) ? 1 : 0;
    for (int k = 0; k < ref_q.size() && k < addr_log.size(); k++)
      if (addr_log[k] != ref_q[k]) bad++;
    checks++;
    if (bad != 0) $display("FAIL b2b_addr_seq: %0d entries with %0d errors, required %0d matching entries",
                           addr_log.size(), bad, ref_q.size());
    else passed++;
  endtask

  task automatic test_extremes;
    int lat, bc, e;
    bit to;
    for (int i = 0; i < 432; i++) b_act[i] = 8'd255;
    for (int i = 0; i < 4320; i++) b_rom[i] = -8'sd128;
    for (int c = 0; c < 10; c++) b_bias[c] = -8'sd128;
    launch(1);
    wait_done(1, lat, bc, to);
    checks++;
    if (to || lat !== 4331) $display("FAIL extremes_latency: edge %0d (timeout=%0d), required 4331", lat, to);
    else passed++;
    checks++;
    if (bc !== 4330) $display("FAIL extremes_busy_cycles: got %0d, required 4330", bc); else passed++;
    for (int c = 0; c < 10; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (b_sc[c] !== e) $display("FAIL extremes_score%0d: got %0d, required %0d", c, b_sc[c], e);
      else passed++;
    end
    e = pred_q.pop_front();
    checks++;
    if (get_pred(1) !== e) $display("FAIL extremes_pred: got %0d, required %0d", b_pred, e); else passed++;
  endtask

  task automatic test_tie;
    int lat, bc, e;
    bit to;
    c_act = '{9, 8, 7, 6};
    for (int i = 0; i < 16; i++) c_rom[i] = '0;
    c_bias = '{7, 9, 9, 1};
    launch(2);
    wait_done(2, lat, bc, to);
    checks++;
    if (to || lat !== 21) $display("FAIL tie_latency: edge %0d (timeout=%0d), required 21", lat, to); else passed++;
    for (int c = 0; c < 4; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (c_sc[c] !== e) $display("FAIL tie_score%0d: got %0d, required %0d", c, c_sc[c], e);
      else passed++;
    end
    e = pred_q.pop_front();
    checks++;
    if (get_pred(2) !== e) $display("FAIL tie_pred: got %0d, required %0d", c_pred, e); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin a_act[i] = '0; c_act[i] = '0; c_bias[i] = '0; end
    for (int i = 0; i < 8; i++) a_rom[i] = '0;
    for (int i = 0; i < 16; i++) c_rom[i] = '0;
    for (int i = 0; i < 2; i++) a_bias[i] = '0;
    for (int i = 0; i < 432; i++) b_act[i] = '0;
    for (int i = 0; i < 4320; i++) b_rom[i] = '0;
    for (int i = 0; i < 10; i++) b_bias[i] = '0;
    test_reset();
    test_basic("basic");
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    test_extremes();
    test_tie();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
